// File: rtl/serial_bridge_pkg.sv
// Shared types and constants for the serial host bridge and its UART engines.
package serial_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_host_bridge_sync_fifo.sv
// Single-clock FIFO with first-word fall-through output. The head byte is
// held in a register so the output is defined after reset and keeps its last
// value once the FIFO drains.
module sync_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int unsigned DEPTH      = 1 << AW;
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          push_eff, pop_eff;

  assign empty = (count_q == '0);
  assign full  = (count_q == COUNT_FULL);
  assign dout  = head_q;

  // Pointer/count bookkeeping and next head-of-queue selection.
  always_comb begin
    push_eff = push && !full;
    pop_eff  = pop && !empty;
    wr_ptr_d = push_eff ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_eff ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_eff && !pop_eff) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_eff && !push_eff) begin
      count_d = count_q - (AW+1)'(1);
    end
    // The new head is the byte being written this cycle when the read
    // pointer lands on the slot under write; otherwise it is already in mem.
    head_d = head_q;
    if (count_d != '0) begin
      if (push_eff && (rd_ptr_d == wr_ptr_q)) begin
        head_d = din;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/serial_host_bridge.sv
// Serial host bridge: CPU byte port <-> TX/RX FIFOs <-> 8N1 UART.
// Optional build macro SERIAL_BRIDGE_LOOPBACK_EN routes the internal TX line
// into the RX synchronizer and parks uart_tx_out at idle.
module serial_host_bridge
  import serial_bridge_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cpu_wdata_in,
  input  logic       cpu_wren_in,
  input  logic       cpu_rden_in,
  output logic [7:0] cpu_rdata_out,
  output logic       cpu_valid_out,
  output logic       cpu_ready_out,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic       framing_err_out,
  output logic       overrun_out
);

  localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  // FIFO interconnect
  logic [7:0] tx_head;
  logic       tx_empty, tx_full, tx_pop;
  logic [7:0] rx_head;
  logic       rx_empty, rx_full, rx_push;

  sync_fifo #(.W(8), .AW(FIFO_AW)) tx_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (cpu_wren_in),
    .din   (cpu_wdata_in),
    .pop   (tx_pop),
    .dout  (tx_head),
    .empty (tx_empty),
    .full  (tx_full)
  );

  // TX engine state
  uart_state_t tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;
  logic          tx_bit_end;

  // TX next-state: the line level is registered from the current state, so
  // each level appears one cycle after its state and lasts CLKS_PER_BIT.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = IDLE_LEVEL;
    tx_pop     = 1'b0;
    tx_bit_end = (tx_cnt_q == BIT_LAST);
    unique case (tx_state_q)
      IDLE: begin
        tx_line_d = IDLE_LEVEL;
        tx_cnt_d  = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_bit_d   = '0;
          tx_state_d = START;
        end
      end
      START: begin
        tx_line_d = 1'b0;
        tx_cnt_d  = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
        if (tx_bit_end) begin
          tx_bit_d   = '0;
          tx_state_d = DATA;
        end
      end
      DATA: begin
        tx_line_d = tx_shift_q[0];
        tx_cnt_d  = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
        if (tx_bit_end) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        tx_line_d = IDLE_LEVEL;
        tx_cnt_d  = tx_bit_end ? '0 : tx_cnt_q + CW'(1);
        if (tx_bit_end) begin
          // Chain straight into the next start bit when more data waits.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_bit_d   = '0;
            tx_state_d = START;
          end else begin
            tx_state_d = IDLE;
          end
        end
      end
    endcase
  end

  // TX engine registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= IDLE_LEVEL;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // Line-side routing
  logic rx_src;
`ifdef SERIAL_BRIDGE_LOOPBACK_EN
  assign rx_src      = tx_line_q;
  assign uart_tx_out = IDLE_LEVEL;
`else
  assign rx_src      = uart_rx_in;
  assign uart_tx_out = tx_line_q;
`endif

  // RX engine state
  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d;
  uart_state_t   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          rx_bit_end;

  // RX next-state. The counter is loaded with 1 on the edge cycle so the
  // start sample at BIT_HALF lands mid-bit; later samples follow every bit.
  always_comb begin
    rx_meta_d  = rx_src;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;
    rx_push    = 1'b0;
    rx_bit_end = (rx_cnt_q == BIT_LAST);
    unique case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          rx_cnt_d   = CW'(1);
          rx_state_d = START;
        end
      end
      START: begin
        if (rx_cnt_q == BIT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? IDLE : DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      DATA: begin
        rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + CW'(1);
        if (rx_bit_end) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == LAST_BIT) begin
            rx_state_d = STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + CW'(1);
        if (rx_bit_end) begin
          rx_state_d = IDLE;
          if (!rx_sync_q) begin
            ferr_d = 1'b1;
          end else if (rx_full) begin
            ovr_d = 1'b1;
          end else begin
            rx_push = 1'b1;
          end
        end
      end
    endcase
  end

  // RX engine and synchronizer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q  <= IDLE_LEVEL;
      rx_sync_q  <= IDLE_LEVEL;
      rx_prev_q  <= IDLE_LEVEL;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  sync_fifo #(.W(8), .AW(FIFO_AW)) rx_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (rx_push),
    .din   (rx_shift_q),
    .pop   (cpu_rden_in),
    .dout  (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  assign cpu_rdata_out   = rx_head;
  assign cpu_valid_out   = !rx_empty;
  assign cpu_ready_out   = !tx_full;
  assign framing_err_out = ferr_q;
  assign overrun_out     = ovr_q;

endmodule

// File: tb/tb_serial_host_bridge.sv
// Scoreboard bench for serial_host_bridge (CLKS_PER_BIT=4, FIFO_AW=2).
module tb_serial_host_bridge;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] cpu_wdata_in;
  logic       cpu_wren_in;
  logic       cpu_rden_in;
  logic [7:0] cpu_rdata_out;
  logic       cpu_valid_out;
  logic       cpu_ready_out;
  logic       uart_rx_in;
  logic       uart_tx_out;
  logic       framing_err_out;
  logic       overrun_out;

  always #5 clock = ~clock;

  serial_host_bridge #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_wdata_in    (cpu_wdata_in),
    .cpu_wren_in     (cpu_wren_in),
    .cpu_rden_in     (cpu_rden_in),
    .cpu_rdata_out   (cpu_rdata_out),
    .cpu_valid_out   (cpu_valid_out),
    .cpu_ready_out   (cpu_ready_out),
    .uart_rx_in      (uart_rx_in),
    .uart_tx_out     (uart_tx_out),
    .framing_err_out (framing_err_out),
    .overrun_out     (overrun_out)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  tx_exp[$];
  logic [7:0]  rx_exp[$];
  longint      start_times[$];
  longint      cyc = 0;
  int unsigned ferr_cnt = 0;
  int unsigned ovr_cnt = 0;
  logic        tx_low_seen = 1'b0;
  logic        mon_abort = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Error pulse counters and idle-line watch, sampled mid-cycle.
  always @(negedge clock) begin
    cyc++;
    if (framing_err_out === 1'b1) ferr_cnt++;
    if (overrun_out === 1'b1) ovr_cnt++;
    if (!reset && uart_tx_out !== 1'b1) tx_low_seen = 1'b1;
  end

  task automatic mon_wait(input int n);
    repeat (n) begin
      @(negedge clock);
      if (reset) mon_abort = 1'b1;
    end
  endtask

  // UART line decoder: pops the TX scoreboard for every complete frame.
  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge clock);
      if (!reset && uart_tx_out === 1'b0) begin
        mon_abort = 1'b0;
        start_times.push_back(cyc);
        mon_wait(CPB / 2);
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB);
          b[i] = uart_tx_out;
        end
        mon_wait(CPB);
        if (!mon_abort) begin
          check("tx_stop_bit", uart_tx_out, 1);
          check("tx_byte_expected", tx_exp.size() != 0, 1);
          if (tx_exp.size() != 0) check("tx_byte", b, tx_exp.pop_front());
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx_in = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      step(CPB);
    end
    uart_rx_in = stop;
    step(CPB);
    uart_rx_in = 1'b1;
  endtask

  task automatic pop_rx(input string tag);
    int n = 0;
    while (cpu_valid_out !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    check({tag, "_valid"}, cpu_valid_out, 1);
    check({tag, "_expected"}, rx_exp.size() != 0, 1);
    if (rx_exp.size() != 0) check({tag, "_data"}, cpu_rdata_out, rx_exp.pop_front());
    cpu_rden_in = 1'b1;
    step(1);
    cpu_rden_in = 1'b0;
  endtask

  task automatic wait_tx_drain(input int budget);
    int n = 0;
    while (tx_exp.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check("tx_drain", tx_exp.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [9:0]  fr;
    logic [39:0] got_v, exp_v;
    logic [5:0]  rdy;
    logic [7:0]  bp [6];
    logic [7:0]  ov [5];
    int unsigned f0, o0;

    reset = 1'b1;
    cpu_wdata_in = '0;
    cpu_wren_in = 1'b0;
    cpu_rden_in = 1'b0;
    uart_rx_in = 1'b1;
    step(3);
    reset = 1'b0;
    check("rst_tx", uart_tx_out, 1);
    check("rst_valid", cpu_valid_out, 0);
    check("rst_ready", cpu_ready_out, 1);
    check("rst_rdata", cpu_rdata_out, 0);
    check("rst_ferr", framing_err_out, 0);
    check("rst_ovr", overrun_out, 0);
    step(2);

`ifdef SERIAL_BRIDGE_LOOPBACK_EN
    tx_low_seen = 1'b0;
    cpu_wren_in = 1'b1;
    cpu_wdata_in = 8'h5A;
    rx_exp.push_back(8'h5A);
    step(1);
    cpu_wdata_in = 8'hFF;
    rx_exp.push_back(8'hFF);
    step(1);
    cpu_wren_in = 1'b0;
    pop_rx("lb_0");
    pop_rx("lb_1");
    step(2);
    check("lb_valid_empty", cpu_valid_out, 0);
    check("lb_tx_held_idle", tx_low_seen, 0);
`else
    // Single byte with exact line timing.
    cpu_wdata_in = 8'hA5;
    cpu_wren_in = 1'b1;
    tx_exp.push_back(8'hA5);
    step(1);
    cpu_wren_in = 1'b0;
    check("tx_idle_push_cycle", uart_tx_out, 1);
    step(1);
    check("tx_idle_pop_cycle", uart_tx_out, 1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) begin
      step(1);
      got_v[k] = uart_tx_out;
      exp_v[k] = fr[k / CPB];
    end
    check("tx_a5_waveform", got_v, exp_v);
    wait_tx_drain(100);
    step(4);

    // Backpressure: six pushes with no gaps into a 4-deep FIFO.
    start_times.delete();
    bp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 6; i++) begin
      cpu_wdata_in = bp[i];
      cpu_wren_in = 1'b1;
      if (i < 5) tx_exp.push_back(bp[i]);
      step(1);
      rdy[i] = cpu_ready_out;
    end
    cpu_wren_in = 1'b0;
    check("tx_ready_seq", rdy, 6'b001111);
    wait_tx_drain(400);
    step(8);
    check("tx_frames_seen", start_times.size(), 5);
    if (start_times.size() >= 5) begin
      for (int k = 1; k < 5; k++)
        check("tx_back_to_back", start_times[k] - start_times[k-1], 10 * CPB);
    end

    // Receive one byte, then pop it.
    rx_exp.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    pop_rx("rx_3c");
    check("rx_valid_after_pop", cpu_valid_out, 0);

    // Framing error.
    f0 = ferr_cnt;
    send_frame(8'h81, 1'b0);
    step(12);
    check("rx_ferr_pulses", ferr_cnt - f0, 1);
    check("rx_ferr_no_byte", cpu_valid_out, 0);

    // Overrun on the fifth unread frame.
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    ov = '{8'hC1, 8'h02, 8'hE3, 8'h74, 8'h95};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) rx_exp.push_back(ov[i]);
      send_frame(ov[i], 1'b1);
    end
    step(12);
    check("rx_ovr_pulses", ovr_cnt - o0, 1);
    check("rx_ovr_no_ferr", ferr_cnt - f0, 0);
    for (int i = 0; i < 4; i++) pop_rx("rx_ovr_fifo");
    check("rx_ovr_drained", cpu_valid_out, 0);

    // One-cycle glitch on the line.
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    uart_rx_in = 1'b0;
    step(1);
    uart_rx_in = 1'b1;
    step(60);
    check("glitch_no_byte", cpu_valid_out, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);
    check("glitch_no_ovr", ovr_cnt - o0, 0);

    // Reset in the middle of a TX frame with a byte waiting in RX.
    send_frame(8'h42, 1'b1);
    step(6);
    check("pre_reset_rx_valid", cpu_valid_out, 1);
    cpu_wdata_in = 8'h77;
    cpu_wren_in = 1'b1;
    step(1);
    cpu_wren_in = 1'b0;
    step(15);
    check("pre_reset_tx_active", tx_low_seen, 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_reset_tx", uart_tx_out, 1);
    check("mid_reset_ready", cpu_ready_out, 1);
    check("mid_reset_valid", cpu_valid_out, 0);
    tx_low_seen = 1'b0;
    step(50);
    check("post_reset_tx_idle", tx_low_seen, 0);
    check("post_reset_rx_empty", cpu_valid_out, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_host_bridge.md
Name: serial_host_bridge

Overview:
Device-side endpoint of the processor's byte-wide serial IO port. Its CPU port connects directly to the processor's serial pins (serial_out/serial_wren_out/serial_rden_out in; serial_in/serial_valid_in/serial_ready_in out). The line side is an 8N1 UART, with a TX FIFO and an RX FIFO between the two sides.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 4.
FIFO_AW, 4, FIFO address width; each FIFO holds 2**FIFO_AW bytes.

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
cpu_wdata_in  input  8  byte from processor (its serial_out)
cpu_wren_in  input  1  push cpu_wdata_in into TX FIFO this cycle
cpu_rden_in  input  1  pop RX FIFO head this cycle
cpu_rdata_out  output  8  RX FIFO head, first-word fall-through (to processor serial_in)
cpu_valid_out  output  1  RX FIFO non-empty (to processor serial_valid_in)
cpu_ready_out  output  1  TX FIFO not full (to processor serial_ready_in)
uart_rx_in  input  1  asynchronous serial line in, idle high
uart_tx_out  output  1  serial line out, idle high
framing_err_out  output  1  one-cycle pulse: received stop bit was 0
overrun_out  output  1  one-cycle pulse: received byte dropped because RX FIFO was full

Behaviour:
- Reset: uart_tx_out=1; cpu_valid_out=0; cpu_ready_out=1; cpu_rdata_out=0; both error pulses=0; both FIFOs empty; both FSMs IDLE; baud counters=0.
- CPU write: cpu_wren_in=1 with cpu_ready_out=1 pushes at the edge. cpu_wren_in while full is ignored (byte lost, no error flag). cpu_ready_out updates the cycle after a push fills the FIFO.
- CPU read: cpu_rdata_out is always the head byte. cpu_rden_in with cpu_valid_out=1 pops at the edge. cpu_rden_in while empty is ignored. cpu_rdata_out holds its last value when empty.
- FIFO simultaneous push+pop: on a non-empty, non-full FIFO, count is unchanged. On an empty FIFO, only the push takes effect. On a full FIFO, the pop takes effect and the push is dropped.
- TX FSM IDLE->START->DATA->STOP->IDLE:
  - IDLE: when the TX FIFO is non-empty, pop the head into the shift register and go to START.
  - START: drive 0 for CLKS_PER_BIT cycles.
  - DATA: drive 8 bits, LSB first, each for CLKS_PER_BIT cycles.
  - STOP: drive 1 for CLKS_PER_BIT cycles.
  - Back-to-back bytes: a new START begins the cycle after STOP ends (no extra idle cycles).
  - Latency: first start-bit cycle appears on uart_tx_out 2 cycles after the push edge.
- RX input: uart_rx_in passes through a 2-flop synchronizer (reset value 1). All RX logic uses the synchronized signal.
- RX FSM IDLE->START->DATA->STOP->IDLE:
  - IDLE: a falling edge (sync 1->0) goes to START and loads the counter.
  - START: sample at CLKS_PER_BIT/2. If 1 (glitch), return to IDLE. If 0, go to DATA.
  - DATA: sample 8 bits at each bit's midpoint, spaced CLKS_PER_BIT apart, LSB first.
  - STOP: sample the stop bit at its midpoint.
    - Stop=1, FIFO not full: push the byte.
    - Stop=1, FIFO full: drop the byte and pulse overrun_out.
    - Stop=0: drop the byte and pulse framing_err_out.
  - STOP then returns to IDLE immediately after the sample, so the next start edge is caught.
- Baud counters count 0..CLKS_PER_BIT-1 and wrap. Counter width is $clog2(CLKS_PER_BIT).
- Reset mid-frame: the TX frame is aborted, uart_tx_out returns to 1 the cycle after reset, and the shift register is cleared. A partial RX frame is discarded.

Optional Feature:
SERIAL_BRIDGE_LOOPBACK_EN:
- Defined: the RX synchronizer input is taken from the internal TX line instead of uart_rx_in, and uart_tx_out is held at 1. Bytes written by the CPU reappear in the RX FIFO one frame later.
- Undefined: normal operation; uart_rx_in is used and uart_tx_out is driven by the TX FSM.

Decomposition:
- Package serial_bridge_pkg:
  - uart_state_t enum (IDLE, START, DATA, STOP), shared by TX and RX
  - DATA_BITS=8
  - IDLE_LEVEL=1'b1
- Sub-module sync_fifo (params W, AW): single clock, synchronous reset, FWFT output. Instantiated twice, as tx_fifo and rx_fifo. TX and RX FSMs stay inline in serial_host_bridge.

Test Plan (CLKS_PER_BIT=4, FIFO_AW=2):
- TX byte: push 0xA5 -> uart_tx_out = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; start bit begins 2 cycles after the push edge.
- TX backpressure: push 6 bytes with no gaps -> cpu_ready_out goes 0 once the FIFO holds 4. The byte offered while full is absent on the line; the remaining bytes are sent back-to-back.
- RX byte: drive frame 0x3C on uart_rx_in -> cpu_valid_out=1 with cpu_rdata_out=0x3C. A cpu_rden_in pulse -> cpu_valid_out=0 next cycle.
- RX errors:
  - Frame with stop=0 -> framing_err_out pulses once, cpu_valid_out stays 0.
  - Send 5 good frames with no reads -> overrun_out pulses once on the 5th; the FIFO holds the first 4 bytes in order.
- Glitch/reset: a 1-cycle low pulse on uart_rx_in -> no byte, no error. Assert reset mid-TX frame -> uart_tx_out=1 the next cycle, cpu_ready_out=1, cpu_valid_out=0.
- Loopback (macro defined): push 0x5A, 0xFF -> cpu_rdata_out reads 0x5A then 0xFF; uart_tx_out stays 1 throughout.
